// File: rtl/rcc_pkg.sv
// Shared encodings and defaults for the clock-mode sequencer.
package rcc_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_STOP_WAIT = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_HALT      = 3'd4
  } rcc_state_e;

  localparam int CNT_W_DEF      = 8;
  localparam int STOP_CYC_DEF   = 4;
  localparam int SETTLE_CYC_DEF = 16;

  localparam logic SEL_LCLK = 1'b0;
  localparam logic SEL_HCLK = 1'b1;

endpackage

// File: rtl/rcc_dly_cnt.sv
// Loadable down-counter timing the stop and settle windows; holds at zero.
module rcc_dly_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rcc_seq.sv
// Clock-mode sequencer: gates runclk, flips clk_sel while gated, then waits a
// settle window before re-enabling runclk. Also handles halt / wake.
module rcc_seq
  import rcc_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STOP_CYC   = STOP_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic sysclk,
  input  logic rst,
  input  logic sw_req,
  input  logic sel_req,
  input  logic halt_req,
  input  logic wake,
  output logic clk_sel,
  output logic run_ctrl,
  output logic busy,
  output logic done
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (STOP_CYC < 1 || STOP_CYC > CNT_MAX) begin : g_bad_stop_cyc
    $error("rcc_seq: STOP_CYC out of range");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > CNT_MAX) begin : g_bad_settle_cyc
    $error("rcc_seq: SETTLE_CYC out of range");
  end

  localparam logic [CNT_W-1:0] STOP_LD   = CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  rcc_state_e       state_q, state_d;
  logic             sel_d, run_d, done_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  rcc_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .sysclk   (sysclk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    sel_d    = clk_sel;
    run_d    = run_ctrl;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        run_d = 1'b1;
        // Halt takes priority; a simultaneous switch request is dropped.
        if (halt_req) begin
          state_d = ST_HALT;
          run_d   = 1'b0;
        end else if (sw_req) begin
          if (sel_req != clk_sel) begin
            state_d  = ST_STOP_WAIT;
            run_d    = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = STOP_LD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_STOP_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_SWITCH;
          sel_d   = ~clk_sel;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SWITCH: begin
        state_d  = ST_SETTLE;
        cnt_load = 1'b1;
        cnt_val  = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HALT: begin
        run_d = 1'b0;
        if (wake) begin
          state_d  = ST_SETTLE;
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LD;
        end
      end
      default: begin
        state_d = ST_RUN;
        run_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      clk_sel  <= SEL_LCLK;
      run_ctrl <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_sel  <= sel_d;
      run_ctrl <= run_d;
      busy     <= (state_d != ST_RUN);
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_rcc_seq.sv
// Directed bench for rcc_seq with default parameters (STOP 4, SETTLE 16).
module tb_rcc_seq;

  logic sysclk = 1'b0;
  logic rst, sw_req, sel_req, halt_req, wake;
  logic clk_sel, run_ctrl, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sysclk = ~sysclk;

  rcc_seq dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .sw_req   (sw_req),
    .sel_req  (sel_req),
    .halt_req (halt_req),
    .wake     (wake),
    .clk_sel  (clk_sel),
    .run_ctrl (run_ctrl),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_sel, input logic e_run,
                            input logic e_busy, input logic e_done);
    check({tag, ".clk_sel"},  clk_sel,  e_sel);
    check({tag, ".run_ctrl"}, run_ctrl, e_run);
    check({tag, ".busy"},     busy,     e_busy);
    check({tag, ".done"},     done,     e_done);
  endtask

  // Full switch to new_sel from ~new_sel; k counts edges from the request edge.
  // Optionally fires ignored sw_req/halt_req pulses at k=2 and k=10.
  task automatic run_switch(input string tag, input logic new_sel, input bit inject);
    sel_req = new_sel;
    sw_req  = 1'b1;
    tick();
    sw_req  = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      check_outs($sformatf("%s.k%0d", tag, k),
                 (k >= 4) ? new_sel : ~new_sel, k >= 21, k < 21, k == 21);
      sw_req   = inject && (k == 1 || k == 9);
      halt_req = inject && (k == 9);
      sel_req  = ~new_sel;
      tick();
    end
    sw_req   = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_req = 1'b0; sel_req = 1'b0; halt_req = 1'b0; wake = 1'b0;

    // 1: reset then idle; wake outside HALT must be ignored.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("rst%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wake = (i >= 4 && i < 7);
      tick();
      check_outs($sformatf("idle%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    wake = 1'b0;

    // 2: switch lclk -> hclk.
    run_switch("sw_h", 1'b1, 1'b0);

    // 5: switch back to lclk with ignored requests in flight.
    run_switch("sw_l_busy", 1'b0, 1'b1);

    // 3: same-source request completes immediately without gating.
    sel_req = 1'b0;
    sw_req  = 1'b1;
    tick();
    sw_req  = 1'b0;
    check_outs("same0", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check_outs("same1", 1'b0, 1'b1, 1'b0, 1'b0);

    // 4: halt and switch together -> halt wins; later wake resumes after 16.
    sel_req  = 1'b1;
    sw_req   = 1'b1;
    halt_req = 1'b1;
    tick();
    sw_req   = 1'b0;
    halt_req = 1'b0;
    check_outs("halt0", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      sw_req = (i == 3);
      tick();
      check_outs($sformatf("halt%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    sw_req = 1'b0;
    wake   = 1'b1;
    tick();
    wake   = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      check_outs($sformatf("wake.k%0d", k), 1'b0, k >= 16, k < 16, k == 16);
      tick();
    end

    // 6: reset at edge 15 of a switch aborts it and restores lclk.
    sel_req = 1'b1;
    sw_req  = 1'b1;
    tick();
    sw_req  = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    check_outs("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs($sformatf("post_rst%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
